// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Imported by the sequencer top.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W    = 4;
  localparam int NIBBLES_MIN = 1;
  localparam int NIBBLES_MAX = 16;

endpackage

// File: rtl/nibble_add_seq_fulladd4bit.sv
// 4-bit ripple slice shared by every nibble of the sequencer.
// overflow is the plain carry out of bit 3.
module fulladd4bit (
  output logic [3:0] s,
  output logic       overflow,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin
);

  logic [4:0] full;

  assign full     = {1'b0, a} + {1'b0, b} + {4'd0, Cin};
  assign s        = full[3:0];
  assign overflow = full[4];

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle W-bit add/subtract using one 4-bit slice,
// one nibble per clock, LSB nibble first.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          carry;
  logic [KW-1:0] k;
  logic [KW+1:0] base;
  logic          last;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_s;
  logic          nib_co;

  assign base  = {k, 2'b00};
  assign last  = (k == K_LAST);
  assign nib_a = op_a[base +: NIBBLE_W];
  assign nib_b = op_b[base +: NIBBLE_W];

  fulladd4bit u_slice (
    .s        (nib_s),
    .overflow (nib_co),
    .a        (nib_a),
    .b        (nib_b),
    .Cin      (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy/done decode straight off the state register
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        (state == RUN): begin
          sum[base +: NIBBLE_W] <= nib_s;
          carry <= nib_co;
          k     <= last ? '0 : k + 1'b1;
          if (last) begin
            cout <= nib_co;
            ovf  <= (op_a[W-1] == op_b[W-1]) &&
                    (nib_s[3] != op_a[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed vector bench for nibble_add_seq (NIBBLES=4).
// Table-driven ops plus held-start and mid-op reset sequences.
module tb_nibble_add_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_chk;
  int n_err;

  typedef struct {
    string       name;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called from IDLE; checks RUN timing, DONE results, return to IDLE.
  task automatic run_op(input vec_t v);
    int bad;
    start = 1'b1;
    sub   = v.sub;
    a     = v.a;
    b     = v.b;
    tick();
    start = 1'b0;
    a     = ~v.a;
    b     = v.a;
    sub   = ~v.sub;
    bad   = 0;
    for (int i = 1; i <= 4; i++) begin
      if (!(busy === 1'b1 && done === 1'b0)) bad++;
      tick();
    end
    chk({v.name, " run_busy"}, bad, 0);
    chk({v.name, " done"}, {busy, done}, 2'b01);
    chk({v.name, " sum"}, sum, v.sum);
    chk({v.name, " cout"}, cout, v.cout);
    chk({v.name, " ovf"}, ovf, v.ovf);
    tick();
    chk({v.name, " idle"}, {busy, done}, 2'b00);
    chk({v.name, " hold"}, {sum, cout, ovf}, {v.sum, v.cout, v.ovf});
  endtask

  initial begin
    int   dones;
    vec_t v;
    n_chk = 0;
    n_err = 0;

    vecs[0] = '{"add_5555", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"add_ripple", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"sub_borrow", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{"add_zero", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{"sub_equal", 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{"add_negovf", 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    chk("reset_state", {busy, done, sum, cout, ovf}, 19'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_op(vecs[i]);

    // start held high; operands swapped at T+2 must not matter
    start = 1'b1;
    sub   = 1'b0;
    a     = 16'h0101;
    b     = 16'h0202;
    tick();
    tick();
    a   = 16'hFFFF;
    b   = 16'hFFFF;
    sub = 1'b1;
    tick();
    tick();
    tick();
    chk("held_done", done, 1'b1);
    chk("held_sum", sum, 16'h0303);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    chk("held_count", dones, 2);
    chk("held_sum2", {sum, cout, ovf}, {16'h0000, 1'b1, 1'b0});
    tick();
    chk("held_idle", {busy, done}, 2'b00);

    // reset during T+2 discards the operation
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h1111;
    sub   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {busy, done, sum, cout, ovf}, 19'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("rst_no_done", dones, 0);
    v = '{"post_rst", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0};
    run_op(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
